lfsr_seq_ctrl: RTL and testbench
================================

Name: lfsr_seq_ctrl

Overview:
Sequencing controller for the team's Fibonacci LFSR built from async-reset D flip-flops.
- Owns seed loading, runs the register for a requested number of steps, supports hold and abort, and signals completion.
- Sits between a host/testbench driver and the LFSR shift chain.
- Gives the LFSR a clean start/busy/done handshake instead of free-running on clk.

Parameters:
WIDTH, 4, LFSR register width in bits
TAPS, 4'b1001, feedback tap mask; feedback bit = XOR-reduce(lfsr_q & TAPS)
CNT_W, 8, width of the step-count request and internal down-counter
RESET_SEED, 4'b0001, value loaded into lfsr_q on reset; width = WIDTH

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
seed_load  input  1  load seed into LFSR (honoured only in IDLE)
seed  input  WIDTH  seed value
start  input  1  request a run (honoured only in IDLE)
num_steps  input  CNT_W  number of LFSR steps for the run; sampled with start
hold  input  1  pause stepping while in RUN
abort  input  1  terminate run while in RUN
lfsr_q  output  WIDTH  current LFSR state
q_valid  output  1  high for one cycle after each step edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse after the final step of a run

Behaviour:
- Reset (async, immediate): state=IDLE, lfsr_q=RESET_SEED, remaining=0, q_valid=0, busy=0, done=0.
- Step function: lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)}. Left shift, feedback into LSB.
- States: IDLE, RUN, DONE. All outputs registered.
- IDLE:
  - seed_load=1: lfsr_q <= seed at the next edge.
  - start=1, num_steps>0: latch remaining=num_steps; go to RUN.
  - start=1, num_steps=0: go to DONE directly. No step is taken.
  - seed_load and start in the same cycle: both are honoured. The seed is loaded on that edge, so the first step uses the new seed.
- RUN:
  - busy=1.
  - Each cycle with hold=0 and abort=0: step lfsr_q, decrement remaining, and set q_valid=1 for the following cycle.
  - When remaining==1 and a step occurs: go to DONE.
  - hold=1: lfsr_q and remaining frozen; q_valid=0.
  - abort=1 (priority over hold and step): go to IDLE at the next edge. No step, no done; lfsr_q retains its value.
- DONE: done=1 for exactly one cycle, then IDLE. start and seed_load are ignored in DONE.
- Latency: start sampled at edge k, RUN from edge k. Steps occur at edges k+1..k+N (without hold). done is high in the cycle after edge k+N+1; the next start is accepted one cycle later.
- seed_load, start and num_steps are ignored outside IDLE.
- An all-zero seed is legal without the optional feature; the LFSR then stays at 0.
- Counter never wraps: remaining only decrements in RUN and RUN exits at 1.

Optional Feature:
LFSR_LOCKUP_GUARD_EN
- Defined:
  - A seed_load with seed==0 loads RESET_SEED instead.
  - An extra output port lockup_err (1 bit, reset 0) pulses high for one cycle after the substituted load.
  - start with lfsr_q==0 is treated like num_steps=0: straight to DONE.
- Undefined: seed loaded verbatim; no lockup_err port.

Decomposition:
- Package lfsr_pkg:
  - state enum {IDLE, RUN, DONE}
  - default TAPS constant (4'b1001, maximal-length for WIDTH=4)
  - default RESET_SEED constant
- Sub-module lfsr_core:
  - WIDTH-bit register with async reset to RESET_SEED
  - inputs load/load_val/step_en; output q
  - feedback XOR inside
- lfsr_seq_ctrl contains the FSM, down-counter and handshake outputs, and instantiates lfsr_core.

Test Plan:
- Reset then idle → lfsr_q=4'b0001, busy=0, done=0, q_valid=0.
- seed_load seed=0001, start num_steps=4 → lfsr_q sequence 0011, 0111, 1111, 1110; q_valid high 4 cycles; done one pulse; busy low after.
- Seed 0001, num_steps=15 → lfsr_q returns to 0001 on the 15th step; all 15 intermediate values distinct.
- Run num_steps=6 with hold=1 for 3 cycles after step 2 → lfsr_q frozen at 0111 during hold; completes 6 steps total, done 3 cycles later than unheld.
- abort after step 3 of num_steps=10 → back to IDLE, lfsr_q=1111, no done pulse. rst asserted mid-run → immediate IDLE, lfsr_q=0001.
- start num_steps=0 → done pulse, lfsr_q unchanged. With LFSR_LOCKUP_GUARD_EN, seed_load seed=0 → lfsr_q=0001, lockup_err one pulse.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR sequencing controller.
// Optional build macro used by this slice: LFSR_LOCKUP_GUARD_EN.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lfsr_state_t;

    // x^4 + x^3 + 1 taps: maximal length (period 15) for a 4-bit register
    localparam logic [3:0] LFSR_DEFAULT_TAPS       = 4'b1001;
    localparam logic [3:0] LFSR_DEFAULT_RESET_SEED = 4'b0001;

endpackage

// File: rtl/lfsr_seq_ctrl_core.sv
// Fibonacci LFSR shift chain: left shift with XOR feedback into the LSB.
// Load has priority over step; the controller never asserts both together.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int                 WIDTH      = 4,
    parameter logic [WIDTH-1:0]   TAPS       = LFSR_DEFAULT_TAPS,
    parameter logic [WIDTH-1:0]   RESET_SEED = LFSR_DEFAULT_RESET_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step_en,
    output logic [WIDTH-1:0] q
);

    logic feedback;

    assign feedback = ^(q & TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step_en) begin
            q <= {q[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Start/busy/done sequencer around lfsr_core: seed loading, counted runs, hold and abort.
// Build option LFSR_LOCKUP_GUARD_EN replaces zero seeds and adds the lockup_err output.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int                 WIDTH      = 4,
    parameter logic [WIDTH-1:0]   TAPS       = LFSR_DEFAULT_TAPS,
    parameter int                 CNT_W      = 8,
    parameter logic [WIDTH-1:0]   RESET_SEED = LFSR_DEFAULT_RESET_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             q_valid,
    output logic             busy,
`ifdef LFSR_LOCKUP_GUARD_EN
    output logic             done,
    output logic             lockup_err
`else
    output logic             done
`endif
);

    lfsr_state_t       state, state_nxt;
    logic [CNT_W-1:0]  remaining, remaining_nxt;
    logic              core_load;
    logic [WIDTH-1:0]  load_val;
    logic              step_en;
    logic              seed_subst;
    logic              start_empty;

    // A run with nothing to do skips RUN entirely and goes straight to the done pulse.
`ifdef LFSR_LOCKUP_GUARD_EN
    assign start_empty = (num_steps == '0) ||
                         ((seed_load ? load_val : lfsr_q) == '0);
`else
    assign start_empty = (num_steps == '0);
`endif

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        core_load     = 1'b0;
        load_val      = seed;
        step_en       = 1'b0;
        seed_subst    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (seed_load) begin
                    core_load = 1'b1;
`ifdef LFSR_LOCKUP_GUARD_EN
                    if (seed == '0) begin
                        load_val   = RESET_SEED;
                        seed_subst = 1'b1;
                    end
`endif
                end
                if (start) begin
                    if (start_empty) begin
                        state_nxt = ST_DONE;
                    end else begin
                        remaining_nxt = num_steps;
                        state_nxt     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (!hold) begin
                    step_en       = 1'b1;
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            q_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            q_valid   <= step_en;
            busy      <= (state_nxt == ST_RUN);
            done      <= (state == ST_DONE);
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockup_err <= 1'b0;
        end else begin
            lockup_err <= seed_subst;
        end
    end
`else
    logic unused_subst;
    assign unused_subst = seed_subst;
`endif

    lfsr_core #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (load_val),
        .step_en  (step_en),
        .q        (lfsr_q)
    );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_lfsr_seq_ctrl;

    localparam int         WIDTH = 4;
    localparam int         CNT_W = 8;
    localparam logic [3:0] TAPS  = 4'b1001;
    localparam logic [3:0] RSEED = 4'b0001;

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             start;
    logic [CNT_W-1:0] num_steps;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] lfsr_q;
    logic             q_valid;
    logic             busy;
    logic             done;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic             lockup_err;
`endif

    lfsr_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed       (seed),
        .start      (start),
        .num_steps  (num_steps),
        .hold       (hold),
        .abort      (abort),
        .lfsr_q     (lfsr_q),
        .q_valid    (q_valid),
        .busy       (busy),
`ifdef LFSR_LOCKUP_GUARD_EN
        .done       (done),
        .lockup_err (lockup_err)
`else
        .done       (done)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = running, 2 = finished (done pulse pending)
    int         m_phase;
    logic [3:0] m_q;
    int         m_left;
    bit         m_qv, m_busy, m_done, m_lerr;

    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        logic [3:0] r;
        r = {v[2:0], 1'b0};
        if (($countones(v & TAPS) % 2) == 1) r[0] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_q = RSEED; m_left = 0;
        m_qv = 0; m_busy = 0; m_done = 0; m_lerr = 0;
    endtask

    task automatic model_edge(input bit sl, input logic [3:0] sd, input bit st,
                              input logic [7:0] n, input bit h, input bit ab);
        bit         stepped, fin, sub, empty;
        logic [3:0] v;
        stepped = 0; sub = 0;
        fin = (m_phase == 2);
        case (m_phase)
            0: begin
                v = sd;
`ifdef LFSR_LOCKUP_GUARD_EN
                if (sl && sd == 4'd0) begin v = RSEED; sub = 1; end
`endif
                if (sl) m_q = v;
                if (st) begin
                    empty = (n == 8'd0);
`ifdef LFSR_LOCKUP_GUARD_EN
                    if (m_q == 4'd0) empty = 1;
`endif
                    if (empty) m_phase = 2;
                    else begin m_left = int'(n); m_phase = 1; end
                end
            end
            1: begin
                if (ab) m_phase = 0;
                else if (!h) begin
                    m_q = lfsr_next(m_q);
                    stepped = 1;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
        m_qv = stepped; m_done = fin; m_lerr = sub; m_busy = (m_phase == 1);
    endtask

    task automatic cyc(input bit sl, input logic [3:0] sd, input bit st,
                       input logic [7:0] n, input bit h, input bit ab);
        seed_load = sl; seed = sd; start = st; num_steps = n; hold = h; abort = ab;
        @(posedge clk);
        model_edge(sl, sd, st, n, h, ab);
        @(negedge clk);
        chk("cyc_lfsr_q", 32'(lfsr_q), 32'(m_q));
        chk("cyc_q_valid", 32'(q_valid), 32'(m_qv));
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
`ifdef LFSR_LOCKUP_GUARD_EN
        chk("cyc_lockup_err", 32'(lockup_err), 32'(m_lerr));
`endif
    endtask

    task automatic idle();
        cyc(0, 4'd0, 0, 8'd0, 0, 0);
    endtask

    // Runs num_steps=6 from seed 1, optionally holding 3 cycles after step 2; returns cycles start..done.
    task automatic run_measure(input bit with_hold, output int cycles);
        int  steps, held;
        bit  h;
        steps = 0; held = 0;
        cyc(1, 4'b0001, 1, 8'd6, 0, 0);
        cycles = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            h = with_hold && (steps == 2) && (held < 3);
            cyc(0, 4'd0, 0, 8'd0, h, 0);
            cycles++;
            if (h) begin
                held++;
                chk("hold_frozen_q", 32'(lfsr_q), 32'h7);
            end
            if (q_valid) steps++;
        end
        chk("hold_reached_done", 32'(done), 32'h1);
        chk("hold_total_steps", 32'(steps), 32'd6);
        idle();
    endtask

    logic [3:0] got[$];
    logic [3:0] exp4[4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};

    initial begin
        int         dn, c_plain, c_held;
        logic [15:0] seen;

        rst = 1'b1; seed_load = 0; seed = '0; start = 0; num_steps = '0; hold = 0; abort = 0;
        model_reset();
        @(negedge clk);
        chk("reset_lfsr_q", 32'(lfsr_q), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_q_valid", 32'(q_valid), 32'h0);
        rst = 1'b0;
        idle();

        // Four steps from seed 0001, seed load coinciding with start
        got.delete(); dn = 0;
        cyc(1, 4'b0001, 1, 8'd4, 0, 0);
        for (int i = 0; i < 8; i++) begin
            idle();
            if (q_valid) got.push_back(lfsr_q);
            if (done) dn++;
        end
        chk("seq4_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("seq4_value", 32'(got[i]), 32'(exp4[i]));
        chk("seq4_done_pulses", 32'(dn), 32'd1);
        chk("seq4_busy_after", 32'(busy), 32'h0);

        // Full period
        got.delete(); seen = '0;
        cyc(1, 4'b0001, 1, 8'd15, 0, 0);
        for (int i = 0; i < 20; i++) begin
            idle();
            if (q_valid) begin got.push_back(lfsr_q); seen[lfsr_q] = 1'b1; end
        end
        chk("seq15_count", 32'(got.size()), 32'd15);
        if (got.size() > 0) chk("seq15_wraps_to_seed", 32'(got[got.size()-1]), 32'h1);
        chk("seq15_distinct", 32'($countones(seen)), 32'd15);

        // Hold delays completion by exactly the held cycles
        run_measure(0, c_plain);
        run_measure(1, c_held);
        chk("hold_delay", 32'(c_held - c_plain), 32'd3);

        // Abort after three steps
        cyc(1, 4'b0001, 1, 8'd10, 0, 0);
        idle(); idle(); idle();
        cyc(0, 4'd0, 0, 8'd0, 0, 1);
        chk("abort_q", 32'(lfsr_q), 32'hF);
        chk("abort_busy", 32'(busy), 32'h0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin idle(); if (done) dn++; end
        chk("abort_no_done", 32'(dn), 32'd0);

        // Asynchronous reset mid-run
        cyc(0, 4'd0, 1, 8'd10, 0, 0);
        idle(); idle();
        rst = 1'b1;
        #1;
        chk("async_rst_q", 32'(lfsr_q), 32'h1);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_q_valid", 32'(q_valid), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        idle();

        // Zero-length run
        cyc(0, 4'd0, 1, 8'd0, 0, 0);
        chk("zero_busy", 32'(busy), 32'h0);
        idle();
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_q_unchanged", 32'(lfsr_q), 32'h1);
        idle();
        chk("zero_done_single", 32'(done), 32'h0);

`ifdef LFSR_LOCKUP_GUARD_EN
        cyc(1, 4'd0, 0, 8'd0, 0, 0);
        chk("guard_q", 32'(lfsr_q), 32'h1);
        chk("guard_err", 32'(lockup_err), 32'h1);
        idle();
        chk("guard_err_single", 32'(lockup_err), 32'h0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 6) == 0, 4'($urandom), ($urandom % 3) == 0,
                8'($urandom % 9), ($urandom % 4) == 0, ($urandom % 20) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
